dpd_mag_index: RTL



---
 rtl/dpd_mag_index.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dpd_mag_index.sv
// Squared-magnitude LUT index stage ahead of the DPD actuator.
// Two I/Q lanes per clock, 3-cycle pipeline, peak and saturation stats.
module dpd_mag_index #(
    parameter int LUT_ADDR_WIDTH = 10
) (
    input  logic                      data_clk,
    input  logic                      data_rst,
    input  logic [31:0]               data_in_0,
    input  logic [31:0]               data_in_1,
    input  logic                      data_in_enable,
    input  logic [4:0]                mag_shift,
    input  logic                      stat_clr,
    output logic [31:0]               data_out_0,
    output logic [31:0]               data_out_1,
    output logic [31:0]               data_out_2,
    output logic                      data_out_enable,
    output logic [LUT_ADDR_WIDTH-1:0] peak_idx,
    output logic [15:0]               sat_count
);

    localparam int W = LUT_ADDR_WIDTH;
    localparam logic [31:0] IDX_MAX = (32'd1 << W) - 32'd1;
    localparam logic [W-1:0] IDX_TOP = IDX_MAX[W-1:0];

    // Signed Q15 square; the result never exceeds 2^30.
    function automatic logic [30:0] sq(input logic [15:0] x);
        logic signed [31:0] e;
        e = 32'(signed'(x));
        return 31'(e * e);
    endfunction

    logic        s1_en;
    logic [31:0] s1_d0;
    logic [31:0] s1_d1;
    logic [30:0] s1_pi0;
    logic [30:0] s1_pq0;
    logic [30:0] s1_pi1;
    logic [30:0] s1_pq1;

    logic        s2_en;
    logic [31:0] s2_d0;
    logic [31:0] s2_d1;
    logic [31:0] s2_m0;
    logic [31:0] s2_m1;

    logic [31:0] t0;
    logic [31:0] t1;
    logic        sat0;
    logic        sat1;
    logic [W-1:0] idx0;
    logic [W-1:0] idx1;
    logic [31:0] idx_word;

    logic        s3_sat0;
    logic        s3_sat1;
    logic [W-1:0] s3_idx0;
    logic [W-1:0] s3_idx1;

    logic [1:0]  nsat;
    logic [16:0] sat_sum;
    logic [15:0] sat_nxt;
    logic [W-1:0] peak_nxt;

    // S1: per-lane squares of I and Q
    always_ff @(posedge data_clk) begin
        if (data_rst) begin
            s1_en  <= 1'b0;
            s1_d0  <= '0;
            s1_d1  <= '0;
            s1_pi0 <= '0;
            s1_pq0 <= '0;
            s1_pi1 <= '0;
            s1_pq1 <= '0;
        end else begin
            s1_en  <= data_in_enable;
            s1_d0  <= data_in_0;
            s1_d1  <= data_in_1;
            s1_pi0 <= sq(data_in_0[15:0]);
            s1_pq0 <= sq(data_in_1[15:0]);
            s1_pi1 <= sq(data_in_0[31:16]);
            s1_pq1 <= sq(data_in_1[31:16]);
        end
    end

    // S2: per-lane |x|^2, at most 2^31 so 32 bits suffice
    always_ff @(posedge data_clk) begin
        if (data_rst) begin
            s2_en <= 1'b0;
            s2_d0 <= '0;
            s2_d1 <= '0;
            s2_m0 <= '0;
            s2_m1 <= '0;
        end else begin
            s2_en <= s1_en;
            s2_d0 <= s1_d0;
            s2_d1 <= s1_d1;
            s2_m0 <= {1'b0, s1_pi0} + {1'b0, s1_pq0};
            s2_m1 <= {1'b0, s1_pi1} + {1'b0, s1_pq1};
        end
    end

    // S3 datapath: shift, saturate and pack the two indices
    always_comb begin
        t0       = s2_m0 >> mag_shift;
        t1       = s2_m1 >> mag_shift;
        sat0     = t0 > IDX_MAX;
        sat1     = t1 > IDX_MAX;
        idx0     = sat0 ? IDX_TOP : t0[W-1:0];
        idx1     = sat1 ? IDX_TOP : t1[W-1:0];
        idx_word = {16'(idx1), 16'(idx0)};
    end

    // S3: output registers, with per-lane results kept for the stats
    always_ff @(posedge data_clk) begin
        if (data_rst) begin
            data_out_enable <= 1'b0;
            data_out_0      <= '0;
            data_out_1      <= '0;
            data_out_2      <= '0;
            s3_sat0         <= 1'b0;
            s3_sat1         <= 1'b0;
            s3_idx0         <= '0;
            s3_idx1         <= '0;
        end else begin
            data_out_enable <= s2_en;
            data_out_0      <= s2_d0;
            data_out_1      <= s2_d1;
            data_out_2      <= idx_word;
            s3_sat0         <= sat0;
            s3_sat1         <= sat1;
            s3_idx0         <= idx0;
            s3_idx1         <= idx1;
        end
    end

    // Next statistics from the sample currently held at S3
    always_comb begin
        nsat     = {1'b0, s3_sat0} + {1'b0, s3_sat1};
        sat_sum  = {1'b0, sat_count} + {15'd0, nsat};
        sat_nxt  = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        peak_nxt = peak_idx;
        if (s3_idx0 > peak_nxt) begin
            peak_nxt = s3_idx0;
        end
        if (s3_idx1 > peak_nxt) begin
            peak_nxt = s3_idx1;
        end
    end

    // Statistics registers; a clear wins over a same-cycle update
    always_ff @(posedge data_clk) begin
        if (data_rst || stat_clr) begin
            peak_idx  <= '0;
            sat_count <= '0;
        end else if (data_out_enable) begin
            peak_idx  <= peak_nxt;
            sat_count <= sat_nxt;
        end
    end

endmodule
